// File: rtl/mem_responder.sv
// Memory-side responder: one read/write at a time from a word RAM after LATENCY wait cycles, plus one I/O register.
// Optional build macro MEM_RESP_IOSYNC_EN adds a two-flop synchronizer on ioIn.
module mem_responder #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 1,
  parameter logic [ADDR_WIDTH-1:0] IO_ADDR = ADDR_WIDTH'(10'h3FF)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [ADDR_WIDTH-1:0] memAdr,
  input  logic [WIDTH-1:0]      writeData,
  output logic [WIDTH-1:0]      readData,
  output logic                  memReady,
  output logic                  memBusy,
  input  logic [WIDTH-1:0]      ioIn,
  output logic [WIDTH-1:0]      ioOut,
  output logic                  errRW
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam state_t FIRST_STATE = (LATENCY > 0) ? S_WAIT : S_ACCESS;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [WIDTH-1:0]      r_wdata;
  logic                  r_is_wr;
  logic [WIDTH-1:0]      r_mem [DEPTH];

  logic [WIDTH-1:0]      w_io_in;
  logic                  w_is_io;
  logic                  w_ram_we;

  assign w_is_io  = (r_adr == IO_ADDR);
  // Reset on the ACCESS edge wins over the commit.
  assign w_ram_we = (r_state == S_ACCESS) && r_is_wr && !w_is_io && !reset;

`ifdef MEM_RESP_IOSYNC_EN
  logic [WIDTH-1:0] r_io_s1;
  logic [WIDTH-1:0] r_io_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_io_s1 <= '0;
      r_io_s2 <= '0;
    end else begin
      r_io_s1 <= ioIn;
      r_io_s2 <= r_io_s1;
    end
  end

  assign w_io_in = r_io_s2;
`else
  assign w_io_in = ioIn;
`endif

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[r_adr] <= r_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_adr    <= '0;
      r_wdata  <= '0;
      r_is_wr  <= 1'b0;
      readData <= '0;
      memReady <= 1'b0;
      memBusy  <= 1'b0;
      ioOut    <= '0;
      errRW    <= 1'b0;
    end else begin
      memReady <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (memRead ^ memWrite) begin
            r_adr   <= memAdr;
            r_wdata <= writeData;
            r_is_wr <= memWrite;
            r_cnt   <= CNT_W'(LATENCY);
            memBusy <= 1'b1;
            r_state <= FIRST_STATE;
          end else if (memRead && memWrite) begin
            errRW <= 1'b1;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_is_wr) begin
            if (w_is_io) begin
              ioOut <= r_wdata;
            end
          end else begin
            readData <= w_is_io ? w_io_in : r_mem[r_adr];
          end
          memReady <= 1'b1;
          r_state  <= S_RESP;
        end
        S_RESP: begin
          memBusy <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: four instances with LATENCY 1, 0, 7 and 3 sharing address/data/ioIn.
module tb_mem_responder;

  logic        clk;
  logic [3:0]  rst;
  logic [3:0]  rd;
  logic [3:0]  wr;
  logic [9:0]  adr;
  logic [15:0] wdata;
  logic [15:0] io_in;
  logic [15:0] rdata  [4];
  logic [15:0] ioout  [4];
  logic [3:0]  ready;
  logic [3:0]  busy;
  logic [3:0]  err;

  int checks = 0;
  int errors = 0;

`ifdef MEM_RESP_IOSYNC_EN
  localparam logic [15:0] EXP_LATE = 16'h1234;
`else
  localparam logic [15:0] EXP_LATE = 16'h5678;
`endif

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_responder #(
      .WIDTH(16),
      .ADDR_WIDTH(10),
      .LATENCY(g == 0 ? 1 : g == 1 ? 0 : g == 2 ? 7 : 3),
      .IO_ADDR(10'h3FF)
    ) u_dut (
      .clk(clk),
      .reset(rst[g]),
      .memRead(rd[g]),
      .memWrite(wr[g]),
      .memAdr(adr),
      .writeData(wdata),
      .readData(rdata[g]),
      .memReady(ready[g]),
      .memBusy(busy[g]),
      .ioIn(io_in),
      .ioOut(ioout[g]),
      .errRW(err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request sampled at edge of cycle 0; returns the cycle memReady is seen (-1 if never within 20).
  task automatic req(input int k, input logic rd_i, input logic wr_i, input logic [9:0] a,
                     input logic [15:0] d, input logic [15:0] io_val,
                     output int cyc, output logic busy_ok);
    @(negedge clk);
    adr   = a;
    wdata = d;
    rd[k] = rd_i;
    wr[k] = wr_i;
    @(posedge clk);
    @(negedge clk);
    rd[k] = 1'b0;
    wr[k] = 1'b0;
    io_in = io_val;
    cyc = -1;
    busy_ok = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      if (n > 1) @(negedge clk);
      if (!busy[k]) busy_ok = 1'b0;
      if (ready[k]) begin
        cyc = n;
        break;
      end
    end
  endtask

  initial begin
    int   cyc;
    logic bok;
    int   nready;

    rst = 4'hF; rd = '0; wr = '0; adr = '0; wdata = '0; io_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 4'h0;

    for (int k = 0; k < 4; k++) begin
      check("rst_rdata", 32'(rdata[k]), 32'h0);
      check("rst_ready", 32'(ready[k]), 32'h0);
      check("rst_busy",  32'(busy[k]),  32'h0);
      check("rst_ioout", 32'(ioout[k]), 32'h0);
      check("rst_err",   32'(err[k]),   32'h0);
    end

    // LATENCY=1 write then read
    req(0, 1'b0, 1'b1, 10'd5, 16'hBEEF, 16'h0, cyc, bok);
    check("wr5_cyc", 32'(cyc), 32'd3);
    check("wr5_busy", 32'(bok), 32'd1);
    check("wr5_ioout", 32'(ioout[0]), 32'h0);
    check("wr5_rdata_kept", 32'(rdata[0]), 32'h0);
    req(0, 1'b1, 1'b0, 10'd5, 16'h0, 16'h0, cyc, bok);
    check("rd5_cyc", 32'(cyc), 32'd3);
    check("rd5_data", 32'(rdata[0]), 32'hBEEF);

    // LATENCY=0 and LATENCY=7 read timing
    req(1, 1'b1, 1'b0, 10'd5, 16'h0, 16'h0, cyc, bok);
    check("lat0_cyc", 32'(cyc), 32'd2);
    check("lat0_busy", 32'(bok), 32'd1);
    req(2, 1'b1, 1'b0, 10'd5, 16'h0, 16'h0, cyc, bok);
    check("lat7_cyc", 32'(cyc), 32'd9);
    check("lat7_busy", 32'(bok), 32'd1);

    // I/O register
    req(0, 1'b0, 1'b1, 10'h3FF, 16'h00A5, 16'h0, cyc, bok);
    check("iowr_cyc", 32'(cyc), 32'd3);
    check("iowr_ioout", 32'(ioout[0]), 32'h00A5);
    check("iowr_rdata_kept", 32'(rdata[0]), 32'hBEEF);
    io_in = 16'h1234;
    repeat (3) @(negedge clk);
    req(0, 1'b1, 1'b0, 10'h3FF, 16'h0, 16'h1234, cyc, bok);
    check("iord_cyc", 32'(cyc), 32'd3);
    check("iord_data", 32'(rdata[0]), 32'h1234);
    req(0, 1'b1, 1'b0, 10'h3FF, 16'h0, 16'h5678, cyc, bok);
    check("iord_late_data", 32'(rdata[0]), 32'(EXP_LATE));
    check("iord_late_ioout", 32'(ioout[0]), 32'h00A5);

    // Both strobes together
    req(0, 1'b1, 1'b1, 10'd5, 16'h1111, 16'h5678, cyc, bok);
    check("both_no_ready", 32'(cyc), 32'hFFFF_FFFF);
    check("both_err", 32'(err[0]), 32'h1);
    check("both_not_busy", 32'(busy[0]), 32'h0);
    req(0, 1'b1, 1'b0, 10'd5, 16'h0, 16'h5678, cyc, bok);
    check("after_err_cyc", 32'(cyc), 32'd3);
    check("after_err_data", 32'(rdata[0]), 32'hBEEF);
    check("after_err_sticky", 32'(err[0]), 32'h1);

    // LATENCY=3: reset during WAIT cancels the write
    req(3, 1'b0, 1'b1, 10'd9, 16'h7777, 16'h5678, cyc, bok);
    check("lat3_wr_cyc", 32'(cyc), 32'd5);
    @(negedge clk);
    adr = 10'd9; wdata = 16'h0001; wr[3] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wr[3] = 1'b0;
    rst[3] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[3] = 1'b0;
    nready = 0;
    for (int n = 0; n < 10; n++) begin
      if (ready[3]) nready++;
      @(negedge clk);
    end
    check("rstwait_no_ready", 32'(nready), 32'd0);
    check("rstwait_busy", 32'(busy[3]), 32'h0);
    req(3, 1'b1, 1'b0, 10'd9, 16'h0, 16'h5678, cyc, bok);
    check("rstwait_rd_cyc", 32'(cyc), 32'd5);
    check("rstwait_rd_data", 32'(rdata[3]), 32'h7777);

    // Strobes during WAIT and RESP are ignored
    @(negedge clk);
    adr = 10'd12; wdata = 16'h4242; wr[0] = 1'b1;
    @(posedge clk);
    nready = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (ready[0]) nready++;
      wr[0] = 1'b0;
      if (n == 1) begin adr = 10'd5; rd[0] = 1'b1; end
      if (n == 2) rd[0] = 1'b0;
      if (n == 3) rd[0] = 1'b1;
      if (n == 4) rd[0] = 1'b0;
    end
    check("ignore_one_ready", 32'(nready), 32'd1);
    check("ignore_rdata_kept", 32'(rdata[0]), 32'hBEEF);
    req(0, 1'b1, 1'b0, 10'd12, 16'h0, 16'h5678, cyc, bok);
    check("ignore_rd12_cyc", 32'(cyc), 32'd3);
    check("ignore_rd12_data", 32'(rdata[0]), 32'h4242);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
